// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline hazard/stall control.
package mips_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/hazard_stall_ctrl_fwd_unit.sv
// Combinational forwarding compare for the Decode and Execute stages.
module fwd_unit #(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] Rs_D,
  input  logic [REG_ADDR_W-1:0] Rt_D,
  input  logic [REG_ADDR_W-1:0] Rs_E,
  input  logic [REG_ADDR_W-1:0] Rt_E,
  input  logic [REG_ADDR_W-1:0] WriteReg_M,
  input  logic [REG_ADDR_W-1:0] WriteReg_W,
  input  logic                  RegWrite_M,
  input  logic                  RegWrite_W,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  ForwardAD,
  output logic                  ForwardBD
);
  import mips_pkg::*;

  logic m_live, w_live;

  // Register 0 is hard-wired, so it never counts as a live destination.
  assign m_live = RegWrite_M && (WriteReg_M != '0);
  assign w_live = RegWrite_W && (WriteReg_W != '0);

  always_comb begin
    ForwardAE = FWD_RF;
    if (m_live && (WriteReg_M == Rs_E))      ForwardAE = FWD_M;
    else if (w_live && (WriteReg_W == Rs_E)) ForwardAE = FWD_W;

    ForwardBE = FWD_RF;
    if (m_live && (WriteReg_M == Rt_E))      ForwardBE = FWD_M;
    else if (w_live && (WriteReg_W == Rt_E)) ForwardBE = FWD_W;
  end

  assign ForwardAD = m_live && (WriteReg_M == Rs_D);
  assign ForwardBD = m_live && (WriteReg_M == Rt_D);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller: forwarding, load-use and branch stalls, and the
// data-memory wait FSM with timeout and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] Rs_D,
  input  logic [REG_ADDR_W-1:0] Rt_D,
  input  logic [REG_ADDR_W-1:0] Rs_E,
  input  logic [REG_ADDR_W-1:0] Rt_E,
  input  logic [REG_ADDR_W-1:0] WriteReg_E,
  input  logic [REG_ADDR_W-1:0] WriteReg_M,
  input  logic [REG_ADDR_W-1:0] WriteReg_W,
  input  logic                  RegWrite_E,
  input  logic                  RegWrite_M,
  input  logic                  RegWrite_W,
  input  logic                  MemtoReg_E,
  input  logic                  MemtoReg_M,
  input  logic                  Branch_D,
  input  logic                  PCSrc_D,
  input  logic                  MemAccess_M,
  input  logic                  dmem_ready,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  ForwardAD,
  output logic                  ForwardBD,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushW,
  output logic                  dmem_req,
  output logic                  mem_err,
  output logic [CNT_W-1:0]      stall_cnt
);
  import mips_pkg::*;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [15:0]      wcnt_q, wcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             mem_err_q;

  logic [1:0] fae, fbe;
  logic       fad, fbd;
  logic       lwstall, brstall, hazard, freeze;

  fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd (
    .Rs_D       (Rs_D),
    .Rt_D       (Rt_D),
    .Rs_E       (Rs_E),
    .Rt_E       (Rt_E),
    .WriteReg_M (WriteReg_M),
    .WriteReg_W (WriteReg_W),
    .RegWrite_M (RegWrite_M),
    .RegWrite_W (RegWrite_W),
    .ForwardAE  (fae),
    .ForwardBE  (fbe),
    .ForwardAD  (fad),
    .ForwardBD  (fbd)
  );

  assign lwstall = MemtoReg_E && ((WriteReg_E == Rs_D) || (WriteReg_E == Rt_D));
  assign brstall = Branch_D &&
                   ((RegWrite_E && ((WriteReg_E == Rs_D) || (WriteReg_E == Rt_D))) ||
                    (MemtoReg_M && ((WriteReg_M == Rs_D) || (WriteReg_M == Rt_D))));
  assign hazard  = lwstall || brstall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wcnt_q      <= '0;
      stall_cnt_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      stall_cnt_q <= stall_cnt_d;
      mem_err_q   <= (state_d == ERR);
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      RUN: begin
        wcnt_d = '0;
        if (MemAccess_M && !dmem_ready) state_d = WAIT;
      end
      WAIT: begin
        // Ready takes priority over a timeout landing in the same cycle.
        if (dmem_ready) begin
          state_d = RUN;
          wcnt_d  = '0;
        end else if (wcnt_q == TMO_LAST) begin
          state_d = ERR;
        end else begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    freeze   = 1'b0;
    dmem_req = 1'b0;
    case (state_q)
      RUN: begin
        dmem_req = MemAccess_M;
        freeze   = MemAccess_M && !dmem_ready;
      end
      WAIT: begin
        dmem_req = 1'b1;
        freeze   = !dmem_ready;
      end
      ERR:     freeze = 1'b1;
      default: freeze = 1'b0;
    endcase

    if (freeze) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b1;
    end else begin
      StallF = hazard;
      StallD = hazard;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = PCSrc_D && !hazard;
      FlushE = hazard;
      FlushW = 1'b0;
    end
    ForwardAE = fae;
    ForwardBE = fbe;
    ForwardAD = fad;
    ForwardBD = fbd;

    if (rst) begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      FlushW    = 1'b0;
      dmem_req  = 1'b0;
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
      ForwardAD = 1'b0;
      ForwardBD = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (StallF && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  assign stall_cnt = stall_cnt_q;
  assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl (TIMEOUT=4, CNT_W=4).
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W;
  logic       RegWrite_E, RegWrite_M, RegWrite_W, MemtoReg_E, MemtoReg_M;
  logic       Branch_D, PCSrc_D, MemAccess_M, dmem_ready;
  logic [1:0] ForwardAE, ForwardBE;
  logic       ForwardAD, ForwardBD;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic       dmem_req, mem_err;
  logic [3:0] stall_cnt;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(
    .REG_ADDR_W (5),
    .TIMEOUT    (4),
    .CNT_W      (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .Rs_D        (Rs_D),
    .Rt_D        (Rt_D),
    .Rs_E        (Rs_E),
    .Rt_E        (Rt_E),
    .WriteReg_E  (WriteReg_E),
    .WriteReg_M  (WriteReg_M),
    .WriteReg_W  (WriteReg_W),
    .RegWrite_E  (RegWrite_E),
    .RegWrite_M  (RegWrite_M),
    .RegWrite_W  (RegWrite_W),
    .MemtoReg_E  (MemtoReg_E),
    .MemtoReg_M  (MemtoReg_M),
    .Branch_D    (Branch_D),
    .PCSrc_D     (PCSrc_D),
    .MemAccess_M (MemAccess_M),
    .dmem_ready  (dmem_ready),
    .ForwardAE   (ForwardAE),
    .ForwardBE   (ForwardBE),
    .ForwardAD   (ForwardAD),
    .ForwardBD   (ForwardBD),
    .StallF      (StallF),
    .StallD      (StallD),
    .StallE      (StallE),
    .StallM      (StallM),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .FlushW      (FlushW),
    .dmem_req    (dmem_req),
    .mem_err     (mem_err),
    .stall_cnt   (stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    {Rs_D, Rt_D, Rs_E, Rt_E}             = '0;
    {WriteReg_E, WriteReg_M, WriteReg_W} = '0;
    {RegWrite_E, RegWrite_M, RegWrite_W} = '0;
    {MemtoReg_E, MemtoReg_M}             = '0;
    {Branch_D, PCSrc_D, MemAccess_M}     = '0;
    dmem_ready                           = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    // Reset: hazards and a pending access present, outputs must stay forced low
    MemtoReg_E = 1'b1; WriteReg_E = 5'd8; Rt_D = 5'd8;
    MemAccess_M = 1'b1; dmem_ready = 1'b0;
    Rs_E = 5'd5; WriteReg_M = 5'd5; RegWrite_M = 1'b1;
    tick();
    settle();
    chk("rst_stallF",  StallF, 0);
    chk("rst_flushE",  FlushE, 0);
    chk("rst_flushW",  FlushW, 0);
    chk("rst_req",     dmem_req, 0);
    chk("rst_fwdAE",   ForwardAE, 0);
    chk("rst_cnt",     stall_cnt, 0);
    chk("rst_err",     mem_err, 0);
    clear_inputs();
    rst = 1'b0;
    tick();

    // Forwarding priority
    Rs_E = 5'd5; Rt_E = 5'd5; WriteReg_M = 5'd5; RegWrite_M = 1'b1;
    WriteReg_W = 5'd5; RegWrite_W = 1'b1;
    settle();
    chk("fwd_AE_M", ForwardAE, 2'b10);
    chk("fwd_BE_M", ForwardBE, 2'b10);
    RegWrite_M = 1'b0;
    settle();
    chk("fwd_AE_W", ForwardAE, 2'b01);
    Rs_E = 5'd0; WriteReg_M = 5'd0; WriteReg_W = 5'd0; RegWrite_M = 1'b1;
    settle();
    chk("fwd_AE_r0", ForwardAE, 2'b00);
    chk("fwd_BE_W",  ForwardBE, 2'b00);
    Rs_D = 5'd7; Rt_D = 5'd0; WriteReg_M = 5'd7;
    settle();
    chk("fwd_AD", ForwardAD, 1);
    chk("fwd_BD", ForwardBD, 0);
    chk("fwd_nostall", StallF, 0);
    tick();
    clear_inputs();

    // Load-use with a taken branch in the same cycle: stall wins, no FlushD
    MemtoReg_E = 1'b1; WriteReg_E = 5'd8; Rt_D = 5'd8; PCSrc_D = 1'b1;
    settle();
    chk("lw_stallF", StallF, 1);
    chk("lw_stallD", StallD, 1);
    chk("lw_flushE", FlushE, 1);
    chk("lw_flushD", FlushD, 0);
    chk("lw_stallE", StallE, 0);
    tick();
    clear_inputs();
    settle();
    chk("lw_release", StallF, 0);
    chk("lw_cnt", stall_cnt, 1);

    // Branch depending on an Execute-stage write
    Branch_D = 1'b1; Rs_D = 5'd3; RegWrite_E = 1'b1; WriteReg_E = 5'd3;
    settle();
    chk("br_stallF", StallF, 1);
    chk("br_flushE", FlushE, 1);
    tick();
    clear_inputs();
    PCSrc_D = 1'b1;
    settle();
    chk("br_flushD", FlushD, 1);
    chk("br_stallF0", StallF, 0);
    chk("br_cnt", stall_cnt, 2);
    tick();
    clear_inputs();
    Branch_D = 1'b1; MemtoReg_M = 1'b1; WriteReg_M = 5'd4; Rt_D = 5'd4;
    settle();
    chk("br_ldM_stallD", StallD, 1);
    tick();
    clear_inputs();

    // Memory wait: 3 not-ready cycles, then ready
    do_reset();
    MemAccess_M = 1'b1; dmem_ready = 1'b0;
    settle();
    chk("mw1_stallM", StallM, 1);
    chk("mw1_flushW", FlushW, 1);
    chk("mw1_req",    dmem_req, 1);
    tick();
    MemtoReg_E = 1'b1; WriteReg_E = 5'd8; Rt_D = 5'd8; PCSrc_D = 1'b1;
    settle();
    chk("mw2_stallE", StallE, 1);
    chk("mw2_flushE", FlushE, 0);
    chk("mw2_flushD", FlushD, 0);
    tick();
    MemtoReg_E = 1'b0; PCSrc_D = 1'b0;
    settle();
    chk("mw3_stallF", StallF, 1);
    tick();
    dmem_ready = 1'b1;
    settle();
    chk("mw4_stallF", StallF, 0);
    chk("mw4_stallM", StallM, 0);
    chk("mw4_flushW", FlushW, 0);
    chk("mw4_req",    dmem_req, 1);
    tick();
    MemAccess_M = 1'b0;
    settle();
    chk("mw_cnt", stall_cnt, 3);
    chk("mw_req_off", dmem_req, 0);

    // Timeout: 1 RUN + 4 WAIT cycles then ERR
    do_reset();
    MemAccess_M = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    settle();
    chk("to_wait_err", mem_err, 0);
    chk("to_wait_req", dmem_req, 1);
    tick();
    settle();
    chk("to_err",     mem_err, 1);
    chk("to_stallF",  StallF, 1);
    chk("to_stallM",  StallM, 1);
    chk("to_flushW",  FlushW, 1);
    chk("to_req",     dmem_req, 0);
    tick();
    dmem_ready = 1'b1;
    settle();
    chk("to_sticky", mem_err, 1);
    rst = 1'b1;
    settle();
    chk("to_rst_stallF", StallF, 0);
    tick();
    rst = 1'b0;
    settle();
    chk("to_clr_err", mem_err, 0);
    chk("to_clr_cnt", stall_cnt, 0);
    chk("to_run_req", dmem_req, 1);
    chk("to_run_stall", StallF, 0);
    tick();

    // Reset in the middle of a wait
    MemAccess_M = 1'b1; dmem_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    settle();
    chk("rw_req_drop", dmem_req, 0);
    tick();
    rst = 1'b0;
    dmem_ready = 1'b1;
    settle();
    chk("rw_run_stall", StallF, 0);
    chk("rw_run_req",   dmem_req, 1);
    chk("rw_cnt",       stall_cnt, 0);
    tick();
    clear_inputs();

    // Saturation: 20 stalled cycles into a 4-bit counter
    do_reset();
    MemtoReg_E = 1'b1; WriteReg_E = 5'd8; Rt_D = 5'd8;
    for (int i = 0; i < 20; i++) tick();
    settle();
    chk("sat_cnt", stall_cnt, 15);
    clear_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
